// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with hold, increment, absolute load, relative branch
// and call/return through a circular hardware return-address stack.
module pc_stack_unit #(
    parameter int                ADDR_W    = 5,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              branch,
    input  logic [ADDR_W-1:0] offset,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_count,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [PTR_W-1:0]  w_wp_inc;
    logic [PTR_W-1:0]  w_wp_dec;
    logic              w_is_empty;
    logic              w_is_full;
    logic              w_push;

    // r_wp is the next slot to write; when full it also points at the oldest entry,
    // so an overflowing push overwrites exactly the entry that must be discarded.
    assign w_pc_inc   = pc_count + ADDR_W'(1);
    assign w_wp_inc   = (r_wp == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
    assign w_wp_dec   = (r_wp == '0) ? PTR_W'(RAS_DEPTH - 1) : r_wp - PTR_W'(1);
    assign w_is_empty = (r_count == '0);
    assign w_is_full  = (r_count == CNT_W'(RAS_DEPTH));
    assign w_push     = !rst && en && !ret && call;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_wp] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_count  <= RESET_VEC;
            r_wp      <= '0;
            r_count   <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ras_err   <= 1'b0;
        end else if (!en) begin
            ras_err <= 1'b0;
        end else begin
            ras_err <= 1'b0;
            if (ret) begin
                if (w_is_empty) begin
                    pc_count <= w_pc_inc;
                    ras_err  <= 1'b1;
                end else begin
                    pc_count  <= r_stack[w_wp_dec];
                    r_wp      <= w_wp_dec;
                    r_count   <= r_count - CNT_W'(1);
                    ras_empty <= (r_count == CNT_W'(1));
                    ras_full  <= 1'b0;
                end
            end else if (call) begin
                pc_count <= data_in;
                r_wp     <= w_wp_inc;
                if (w_is_full) begin
                    ras_err <= 1'b1;
                end else begin
                    r_count   <= r_count + CNT_W'(1);
                    ras_empty <= 1'b0;
                    ras_full  <= (r_count == CNT_W'(RAS_DEPTH - 1));
                end
            end else if (load) begin
                pc_count <= data_in;
            end else if (branch) begin
                pc_count <= pc_count + offset;
            end else begin
                pc_count <= w_pc_inc;
            end
        end
    end
endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios followed by random traffic, all
// checked against a queue-based model of the PC and return stack.
module tb_pc_stack_unit;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              load = 1'b0;
  logic [ADDR_W-1:0] data_in = '0;
  logic              branch = 1'b0;
  logic [ADDR_W-1:0] offset = '0;
  logic              call = 1'b0;
  logic              ret = 1'b0;
  logic [ADDR_W-1:0] pc_count;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int                m_pc  = 0;
  bit                m_err = 1'b0;
  logic [ADDR_W-1:0] exp_q[$];

  pc_stack_unit #(.ADDR_W(ADDR_W), .RESET_VEC(5'd0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
    .branch(branch), .offset(offset), .call(call), .ret(ret),
    .pc_count(pc_count), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pc"}, int'(pc_count), m_pc);
    check({tag, "_empty"}, int'(ras_empty), int'(exp_q.size() == 0));
    check({tag, "_full"}, int'(ras_full), int'(exp_q.size() == DEPTH));
    check({tag, "_err"}, int'(ras_err), int'(m_err));
  endtask

  // Next state straight from the rule list: priority en=0 > ret > call > load > branch > inc.
  task automatic model_step();
    m_err = 1'b0;
    if (!en) return;
    if (ret) begin
      if (exp_q.size() > 0) m_pc = int'(exp_q.pop_back());
      else begin
        m_pc  = (m_pc + 1) % 32;
        m_err = 1'b1;
      end
    end else if (call) begin
      exp_q.push_back(ADDR_W'((m_pc + 1) % 32));
      if (exp_q.size() > DEPTH) begin
        void'(exp_q.pop_front());
        m_err = 1'b1;
      end
      m_pc = int'(data_in);
    end else if (load) m_pc = int'(data_in);
    else if (branch) m_pc = (m_pc + int'(offset)) % 32;
    else m_pc = (m_pc + 1) % 32;
  endtask

  task automatic cycle(input string tag, input bit c_en, input bit c_load, input int c_data,
                       input bit c_branch, input int c_off, input bit c_call, input bit c_ret);
    en = c_en; load = c_load; data_in = ADDR_W'(c_data);
    branch = c_branch; offset = ADDR_W'(c_off); call = c_call; ret = c_ret;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    m_pc = 0; m_err = 1'b0; exp_q.delete();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // 1: count up from reset, then load and wrap
    do_reset();
    idle("t1_inc"); idle("t1_inc"); idle("t1_inc");
    check("t1_pc3", int'(pc_count), 3);
    cycle("t1_load", 1, 1, 30, 0, 0, 0, 0);
    idle("t1_31");
    idle("t1_wrap");
    check("t1_pc0", int'(pc_count), 0);
    // 2: branches and hold
    idle("t2_inc"); idle("t2_inc");
    cycle("t2_bneg", 1, 0, 0, 1, 5'b11101, 0, 0);
    check("t2_pc31", int'(pc_count), 31);
    cycle("t2_bpos", 1, 0, 0, 1, 4, 0, 0);
    cycle("t2_hold", 0, 1, 17, 0, 0, 0, 0);
    check("t2_pc3", int'(pc_count), 3);
    // 3: call / return
    idle("t3_inc"); idle("t3_inc");
    cycle("t3_call", 1, 0, 20, 0, 0, 1, 0);
    idle("t3_inc"); idle("t3_inc");
    cycle("t3_ret", 1, 0, 0, 0, 0, 0, 1);
    check("t3_pc6", int'(pc_count), 6);
    // 4: underflow
    cycle("t4_uflow", 1, 0, 0, 0, 0, 0, 1);
    check("t4_err", int'(ras_err), 1);
    idle("t4_errclr");
    // 5: overflow then drain
    cycle("t5_load0", 1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cycle("t5_call", 1, 0, i, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle("t5_ret", 1, 0, 0, 0, 0, 0, 1);
      check("t5_retpc", int'(pc_count), 5 - i);
    end
    // 6: ret beats call, async reset mid-cycle
    cycle("t6_load", 1, 1, 5, 0, 0, 0, 0);
    cycle("t6_call", 1, 0, 10, 0, 0, 1, 0);
    cycle("t6_both", 1, 1, 20, 1, 3, 1, 1);
    check("t6_pc6", int'(pc_count), 6);
    cycle("t6_call2", 1, 0, 9, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    m_pc = 0; m_err = 1'b0; exp_q.delete();
    check_all("t6_async");
    @(negedge clk);
    rst = 1'b0;
    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, int'($urandom_range(0, 31)),
            $urandom_range(0, 4) == 0, int'($urandom_range(0, 31)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
